tc_queue: RTL and testbench
===========================

# tc_queue

- Synchronous first-word-fall-through FIFO that sits directly upstream of the delay-line component and drives that component's `in` port.
- Absorbs bursts from a producer stage and presents the head entry as a stable registered value, so the downstream negedge sampling always sees settled data.
- Part of the builtin-components library; instantiated by generated netlists the same way as the other `TC_*` components.

## Interface
Parameters:
- `UUID`, 0, instance identifier; not used by logic.
- `NAME`, "", instance name; not used by logic.
- `BIT_WIDTH`, 8, entry width in bits; ≥1.
- `DEPTH`, 16, number of entries; power of two, ≥2.

Ports:
- `clk`  input  1  clock; all state changes on the rising edge.
- `rst`  input  1  reset; asynchronous, active-high.
- `push`  input  1  write request for `in` this cycle.
- `in`  input  BIT_WIDTH  write data.
- `pop`  input  1  consume the head entry this cycle.
- `out`  output  BIT_WIDTH  head entry, registered; 0 when empty.
- `empty`  output  1  no valid entries.
- `full`  output  1  DEPTH entries held.
- `err`  output  1  sticky: set on a rejected push or a rejected pop.
- `count`  output  $clog2(DEPTH)+1  occupancy; present only with `TC_QUEUE_COUNT_EN`.

## Operation
- **State:** storage array `mem[DEPTH]`, read pointer `rd_ptr`, write pointer `wr_ptr` (each $clog2(DEPTH) bits, natural wrap), occupancy `occ` (0..DEPTH), `out` register, `err` register.
- **Reset (asynchronous assert):** `rd_ptr = wr_ptr = 0`, `occ = 0`, `out = 0`, `empty = 1`, `full = 0`, `err = 0`, `count = 0`. Storage contents are not reset. Deassertion takes effect at the next rising edge.
- **Push accepted:** when `push && (!full || pop)`. Writes `mem[wr_ptr] <= in`, then `wr_ptr++`.
- **Pop accepted:** when `pop && !empty`. Advances `rd_ptr++`.
- **Occupancy update:**
  - `occ += 1` for push only.
  - `occ -= 1` for pop only.
  - unchanged for both or neither.
- **Full plus simultaneous push and pop:** both accepted; `full` stays 1.
- **Empty plus simultaneous push and pop:** pop rejected, push accepted, `err` set; `occ` becomes 1.
- **Rejected push** (`push && full && !pop`): data dropped, state unchanged, `err <= 1`.
- **Rejected pop** (`pop && empty`): state unchanged, `err <= 1`.
- **`err` clearing:** only reset clears it.
- **`out` update** each edge to the next-state head entry:
  - If the next occupancy is 0: `out <= 0`.
  - Else if the queue is empty now and a push is accepted: `out <= in` (write-through; no array read).
  - Else: `out <= mem[next rd_ptr]`, or `in` when that slot is being written this edge.
- **Flags:** `empty = (occ == 0)` and `full = (occ == DEPTH)`, both derived from registered `occ`. No output depends combinationally on `push`, `pop` or `in`.

## Timing
- **Push-to-output latency:** 1 cycle. A push accepted at edge k makes `out` valid and `empty = 0` immediately after edge k.
- **Pop:** a pop accepted at edge k presents the next entry on `out` after edge k.
- **Sustained rate:** one push and one pop per cycle.
- **Output stability:** all outputs change only after rising edges (or on async reset). They are stable across the falling edge at which the downstream delay line samples.
- **Reset during traffic:** reset asserted mid-burst discards all entries immediately. The first push after deassertion behaves as push-into-empty.
- **Pointer wrap:** `wr_ptr` and `rd_ptr` wrap from DEPTH-1 to 0 with no bubble.

## Configuration
- **`TC_QUEUE_COUNT_EN` defined:** the `count` port exists and equals `occ`, updating on the same edge as the flags.
- **`TC_QUEUE_COUNT_EN` undefined:** no `count` port. `occ` remains internal; all other behaviour is identical.

## Structure
- **Shared package `tc_pkg`:** holds the pointer-width and occupancy-width helper localparams/functions (`$clog2`-based). No typedefs are needed beyond these.
- **Sub-module `tc_queue_mem`:** the DEPTH×BIT_WIDTH storage array.
  - One synchronous write port and one asynchronous read port.
  - No reset.
  - Keeps the control logic (pointers, occupancy, `out` register, `err`) separate from storage.

## Test plan
- **Reset:** assert `rst` mid-cycle with 3 entries held → `empty = 1`, `out = 0`, `err = 0` immediately, without waiting for a clock edge.
- **Ordering, DEPTH=4, BIT_WIDTH=8:** push 0x11, 0x22, 0x33, 0x44 → `full = 1` after the 4th edge. Then pop four times → `out` sequence 0x11, 0x22, 0x33, 0x44, then 0 with `empty = 1`. `err` stays 0.
- **Overflow:** push 0x55 when full without pop → entry dropped, `err = 1`. Subsequent pops still return 0x11..0x44.
- **Full with simultaneous push and pop:** full queue, push 0xAA with pop → `out` advances to 0x22, `full` stays 1. After three more pops, `out = 0xAA`.
- **Empty with simultaneous push and pop:** push 0x7E with pop on an empty queue → `out = 0x7E` and `empty = 0` after the edge, `err = 1`. With `TC_QUEUE_COUNT_EN`, `count = 1`.
- **Wrap stress:** 100 cycles of continuous push and pop with incrementing data after pre-filling 2 entries, DEPTH=4 → `out` is always data pushed 2 accepted pushes earlier. `count` stays 2, no flag toggles.

Source files
------------

// File: rtl/tc_pkg.sv
// Shared width helpers for the builtin TC_* components.
package tc_pkg;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int occ_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/tc_queue_mem.sv
// Storage array for tc_queue: one synchronous write port, one asynchronous read port, no reset.
module tc_queue_mem #(
    parameter int BIT_WIDTH = 8,
    parameter int DEPTH     = 16,
    parameter int PTR_W     = 4
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [PTR_W-1:0]     waddr,
    input  logic [BIT_WIDTH-1:0] wdata,
    input  logic [PTR_W-1:0]     raddr,
    output logic [BIT_WIDTH-1:0] rdata
);

    logic [BIT_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/tc_queue.sv
// First-word-fall-through FIFO feeding the delay line; out is registered so negedge samplers see settled data.
// Optional occupancy port enabled by defining TC_QUEUE_COUNT_EN.
module tc_queue
    import tc_pkg::*;
#(
    parameter int    UUID      = 0,
    parameter string NAME      = "",
    parameter int    BIT_WIDTH = 8,
    parameter int    DEPTH     = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [BIT_WIDTH-1:0]          in,
    input  logic                          pop,
    output logic [BIT_WIDTH-1:0]          out,
    output logic                          empty,
    output logic                          full,
`ifdef TC_QUEUE_COUNT_EN
    output logic [occ_width(DEPTH)-1:0]   count,
`endif
    output logic                          err
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int OCC_W = occ_width(DEPTH);

    logic [PTR_W-1:0]     rd_ptr, wr_ptr, rd_nxt;
    logic [OCC_W-1:0]     occ, occ_nxt;
    logic [BIT_WIDTH-1:0] rdata, out_nxt;
    logic                 push_acc, pop_acc, err_nxt;

    assign empty = (occ == '0);
    assign full  = (occ == OCC_W'(DEPTH));

`ifdef TC_QUEUE_COUNT_EN
    assign count = occ;
`endif

    assign push_acc = push && (!full || pop);
    assign pop_acc  = pop && !empty;
    assign err_nxt  = err || (push && !push_acc) || (pop && !pop_acc);
    assign rd_nxt   = pop_acc ? rd_ptr + 1'b1 : rd_ptr;

    always_comb begin
        occ_nxt = occ;
        if (push_acc && !pop_acc)      occ_nxt = occ + 1'b1;
        else if (!push_acc && pop_acc) occ_nxt = occ - 1'b1;
    end

    // The next head slot may be the one written on this same edge; bypass the array then.
    always_comb begin
        out_nxt = rdata;
        if (occ_nxt == '0)                      out_nxt = '0;
        else if (empty && push_acc)             out_nxt = in;
        else if (push_acc && rd_nxt == wr_ptr)  out_nxt = in;
    end

    tc_queue_mem #(
        .BIT_WIDTH (BIT_WIDTH),
        .DEPTH     (DEPTH),
        .PTR_W     (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (push_acc),
        .waddr (wr_ptr),
        .wdata (in),
        .raddr (rd_nxt),
        .rdata (rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
            out    <= '0;
            err    <= 1'b0;
        end else begin
            rd_ptr <= rd_nxt;
            if (push_acc) wr_ptr <= wr_ptr + 1'b1;
            occ    <= occ_nxt;
            out    <= out_nxt;
            err    <= err_nxt;
        end
    end

endmodule

// File: tb/tb_tc_queue.sv
// Self-checking bench for tc_queue (DEPTH=4, BIT_WIDTH=8): vector table plus scoreboard wrap stress.
module tb_tc_queue;

    localparam int BW    = 8;
    localparam int DEPTH = 4;
    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          push = 1'b0;
    logic          pop = 1'b0;
    logic [BW-1:0] din = '0;
    logic [BW-1:0] out;
    logic          empty, full, err;
`ifdef TC_QUEUE_COUNT_EN
    logic [OCC_W-1:0] count;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic          push;
        logic          pop;
        logic [BW-1:0] din;
        logic [BW-1:0] exp_out;
        logic          exp_empty;
        logic          exp_full;
        logic          exp_err;
        int            exp_cnt;
    } vec_t;

    vec_t          vecs[$];
    logic [BW-1:0] sb[$];

    tc_queue #(
        .UUID      (0),
        .NAME      ("q0"),
        .BIT_WIDTH (BW),
        .DEPTH     (DEPTH)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .in    (din),
        .pop   (pop),
        .out   (out),
        .empty (empty),
        .full  (full),
`ifdef TC_QUEUE_COUNT_EN
        .count (count),
`endif
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic p, input logic q, input logic [BW-1:0] d,
                       input logic [BW-1:0] eo, input logic ee, input logic ef,
                       input logic er, input int ec);
        vec_t v;
        v.push = p; v.pop = q; v.din = d; v.exp_out = eo;
        v.exp_empty = ee; v.exp_full = ef; v.exp_err = er; v.exp_cnt = ec;
        vecs.push_back(v);
    endtask

    // Inputs change 1 time unit after the rising edge; outputs sampled at the same point.
    task automatic step(input logic p, input logic q, input logic [BW-1:0] d);
        push = p; pop = q; din = d;
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0;
    endtask

    initial begin
        // Reset asserted at time zero
        #1;
        chk("rst_out", 32'(out), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_err", 32'(err), 0);
        #11 rst = 1'b0;
        @(posedge clk); #1;

        // Ordering
        add(1,0,8'h11, 8'h11,0,0,0,1);
        add(1,0,8'h22, 8'h11,0,0,0,2);
        add(1,0,8'h33, 8'h11,0,0,0,3);
        add(1,0,8'h44, 8'h11,0,1,0,4);
        add(0,1,8'h00, 8'h22,0,0,0,3);
        add(0,1,8'h00, 8'h33,0,0,0,2);
        add(0,1,8'h00, 8'h44,0,0,0,1);
        add(0,1,8'h00, 8'h00,1,0,0,0);
        // Overflow: push 0x55 into a full queue is dropped
        add(1,0,8'h11, 8'h11,0,0,0,1);
        add(1,0,8'h22, 8'h11,0,0,0,2);
        add(1,0,8'h33, 8'h11,0,0,0,3);
        add(1,0,8'h44, 8'h11,0,1,0,4);
        add(1,0,8'h55, 8'h11,0,1,1,4);
        add(0,1,8'h00, 8'h22,0,0,1,3);
        add(0,1,8'h00, 8'h33,0,0,1,2);
        add(0,1,8'h00, 8'h44,0,0,1,1);
        add(0,1,8'h00, 8'h00,1,0,1,0);
        // Full with simultaneous push and pop
        add(1,0,8'h11, 8'h11,0,0,1,1);
        add(1,0,8'h22, 8'h11,0,0,1,2);
        add(1,0,8'h33, 8'h11,0,0,1,3);
        add(1,0,8'h44, 8'h11,0,1,1,4);
        add(1,1,8'hAA, 8'h22,0,1,1,4);
        add(0,1,8'h00, 8'h33,0,0,1,3);
        add(0,1,8'h00, 8'h44,0,0,1,2);
        add(0,1,8'h00, 8'hAA,0,0,1,1);
        add(0,1,8'h00, 8'h00,1,0,1,0);
        // Empty with simultaneous push and pop
        add(1,1,8'h7E, 8'h7E,0,0,1,1);
        add(0,1,8'h00, 8'h00,1,0,1,0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].push, vecs[i].pop, vecs[i].din);
            chk($sformatf("v%0d_out", i), 32'(out), 32'(vecs[i].exp_out));
            chk($sformatf("v%0d_empty", i), 32'(empty), 32'(vecs[i].exp_empty));
            chk($sformatf("v%0d_full", i), 32'(full), 32'(vecs[i].exp_full));
            chk($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
`ifdef TC_QUEUE_COUNT_EN
            chk($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].exp_cnt));
`endif
        end

        // Async reset mid-cycle with 3 entries held (err is already set)
        step(1,0,8'hC1);
        step(1,0,8'hC2);
        step(1,0,8'hC3);
        chk("pre_rst_out", 32'(out), 32'h0C1);
        #2 rst = 1'b1;
        #1;
        chk("arst_empty", 32'(empty), 1);
        chk("arst_out", 32'(out), 0);
        chk("arst_err", 32'(err), 0);
        chk("arst_full", 32'(full), 0);
        #3 rst = 1'b0;
        @(posedge clk); #1;
        step(1,0,8'hD5);
        chk("post_rst_out", 32'(out), 32'h0D5);
        chk("post_rst_empty", 32'(empty), 0);
        step(0,1,8'h00);
        chk("post_rst_drain", 32'(empty), 1);

        // Wrap stress: pre-fill 2, then continuous push+pop through the scoreboard
        sb.delete();
        for (int i = 0; i < 2; i++) begin
            sb.push_back(BW'(i));
            step(1,0,BW'(i));
        end
        chk("prefill_out", 32'(out), 0);
        for (int i = 2; i < 102; i++) begin
            sb.push_back(BW'(i));
            void'(sb.pop_front());
            step(1,1,BW'(i));
            chk($sformatf("wrap%0d_out", i), 32'(out), 32'(sb[0]));
            chk($sformatf("wrap%0d_flags", i), {30'd0, empty, full}, 0);
`ifdef TC_QUEUE_COUNT_EN
            chk($sformatf("wrap%0d_count", i), 32'(count), 2);
`endif
        end
        chk("wrap_err", 32'(err), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
